// File: rtl/knn_distance_unit.sv
// Streaming squared-Euclidean distance stage feeding the KNN ordered list chain.
// One coordinate per cycle in, one saturated distance plus index pulse per point out.
module knn_distance_unit #(
  parameter int DATA_W = 16,
  parameter int DIMS   = 2,
  parameter int COMP_W = 32,
  parameter int BAG_W  = 32,
  localparam int AW = (DIMS > 1) ? $clog2(DIMS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_wr,
  input  logic [AW-1:0]     test_addr,
  input  logic [DATA_W-1:0] test_data,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_coord,
  input  logic              in_last,
  output logic              out_valid,
  output logic [COMP_W-1:0] out_dist,
  output logic [BAG_W-1:0]  out_index,
  output logic              busy,
  output logic              done
);

  localparam int ACC_W = 2*DATA_W + 2 + $clog2(DIMS);
  localparam int XW = ((ACC_W > COMP_W) ? ACC_W : COMP_W) + 1;
  localparam logic [XW-1:0] LIM = (XW'(1) << COMP_W) - XW'(2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] test_q [DIMS];
  logic [AW-1:0] dim;
  logic [BAG_W-1:0] idx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic s1_valid, s1_first, s1_lastd, s1_final;
  logic signed [DATA_W:0] s1_diff;
  logic signed [2*DATA_W+1:0] sq;
  logic [XW-1:0] acc_x, sat;
  logic accept, last_dim;

  assign accept   = in_valid & in_ready;
  assign last_dim = (dim == AW'(DIMS-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (accept && last_dim && in_last) state_nx = DRAIN;
      DRAIN:   if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN);
    busy     = (state != IDLE) | s1_valid;
  end

  // Test point is frozen once a pass starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIMS; i++) test_q[i] <= '0;
    end else if (state == IDLE && test_wr && int'(test_addr) < DIMS) begin
      test_q[test_addr] <= test_data;
    end
  end

  always_comb begin
    sq     = s1_diff * s1_diff;
    acc_nx = s1_first ? ACC_W'($unsigned(sq))
                      : acc + ACC_W'($unsigned(sq));
    acc_x  = XW'(acc_nx);
    sat    = (acc_x > LIM) ? LIM : acc_x;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dim       <= '0;
      idx       <= '0;
      acc       <= '0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_lastd  <= 1'b0;
      s1_final  <= 1'b0;
      s1_diff   <= '0;
      out_valid <= 1'b0;
      out_dist  <= '0;
      out_index <= '0;
      done      <= 1'b0;
    end else begin
      s1_valid  <= accept;
      out_valid <= s1_valid & s1_lastd;
      done      <= s1_valid & s1_lastd & s1_final;
      if (accept) begin
        s1_diff  <= $signed({in_coord[DATA_W-1], in_coord})
                  - $signed({test_q[dim][DATA_W-1], test_q[dim]});
        s1_first <= (dim == '0);
        s1_lastd <= last_dim;
        s1_final <= last_dim & in_last;
        dim      <= last_dim ? '0 : dim + AW'(1);
      end
      if (s1_valid) acc <= acc_nx;
      if (s1_valid && s1_lastd) begin
        out_dist  <= COMP_W'(sat);
        out_index <= idx;
        idx       <= idx + BAG_W'(1);
      end
      if (state == IDLE && start) begin
        dim <= '0;
        idx <= '0;
        acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_knn_distance_unit.sv
// Directed bench for knn_distance_unit: default instance plus a
// narrow instance (COMP_W=16, BAG_W=2) driven by the same stimulus.
module tb_knn_distance_unit;

  logic clk = 0;
  logic rst = 1;
  logic test_wr = 0;
  logic [0:0] test_addr = '0;
  logic [15:0] test_data = '0;
  logic start = 0;
  logic in_valid = 0;
  logic [15:0] in_coord = '0;
  logic in_last = 0;

  logic d_ready, d_valid, d_busy, d_done;
  logic [31:0] d_dist, d_index;
  logic s_ready, s_valid, s_busy, s_done;
  logic [15:0] s_dist;
  logic [1:0] s_index;

  int cyc = 0;
  int nvec = 0;
  int nmis = 0;

  logic [63:0] got_dist[$], got_idx[$], got_done[$], got_cyc[$];
  logic [63:0] sgot_dist[$], sgot_idx[$];
  logic [63:0] exp_dist[$], exp_idx[$], exp_cyc[$];
  logic [63:0] sexp_dist[$], sexp_idx[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  knn_distance_unit u_dut (
    .clk(clk), .rst(rst),
    .test_wr(test_wr), .test_addr(test_addr), .test_data(test_data),
    .start(start), .in_valid(in_valid), .in_ready(d_ready),
    .in_coord(in_coord), .in_last(in_last),
    .out_valid(d_valid), .out_dist(d_dist), .out_index(d_index),
    .busy(d_busy), .done(d_done)
  );

  knn_distance_unit #(.COMP_W(16), .BAG_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .test_wr(test_wr), .test_addr(test_addr), .test_data(test_data),
    .start(start), .in_valid(in_valid), .in_ready(s_ready),
    .in_coord(in_coord), .in_last(in_last),
    .out_valid(s_valid), .out_dist(s_dist), .out_index(s_index),
    .busy(s_busy), .done(s_done)
  );

  always @(negedge clk) begin
    if (d_valid) begin
      got_dist.push_back(64'(d_dist));
      got_idx.push_back(64'(d_index));
      got_done.push_back(64'(d_done));
      got_cyc.push_back(64'(cyc));
    end
    if (s_valid) begin
      sgot_dist.push_back(64'(s_dist));
      sgot_idx.push_back(64'(s_index));
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic a, input logic [15:0] v);
    test_wr = 1; test_addr = a; test_data = v;
    @(negedge clk);
    test_wr = 0;
  endtask

  task automatic go();
    start = 1;
    @(negedge clk);
    start = 0;
    chk("start_ready", d_ready, 1);
    chk("start_busy", d_busy, 1);
  endtask

  task automatic push(input logic [15:0] c, input logic l, input logic ld);
    int n = 0;
    in_valid = 1; in_coord = c; in_last = l;
    while (!d_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!d_ready) chk("ready_timeout", d_ready, 1);
    if (ld) exp_cyc.push_back(64'(cyc + 2));
    @(negedge clk);
  endtask

  task automatic gap();
    in_valid = 0; in_last = 0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic expect_pt(input logic [63:0] d, input logic [63:0] sd,
                           input logic [63:0] i, input logic [63:0] si);
    exp_dist.push_back(d); sexp_dist.push_back(sd);
    exp_idx.push_back(i); sexp_idx.push_back(si);
  endtask

  task automatic wait_idle();
    int n = 0;
    in_valid = 0; in_last = 0;
    while (d_busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", d_busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare();
    int ne;
    ne = exp_dist.size();
    chk("n_out", got_dist.size(), ne);
    chk("n_sat", sgot_dist.size(), sexp_dist.size());
    for (int i = 0; i < ne; i++) begin
      chk("dist", i < got_dist.size() ? got_dist[i] : '1, exp_dist[i]);
      chk("index", i < got_idx.size() ? got_idx[i] : '1, exp_idx[i]);
      chk("done", i < got_done.size() ? got_done[i] : '1, 64'(i == ne-1));
      chk("latency", i < got_cyc.size() ? got_cyc[i] : '1,
          i < exp_cyc.size() ? exp_cyc[i] : '0);
      chk("sat_dist", i < sgot_dist.size() ? sgot_dist[i] : '1, sexp_dist[i]);
      chk("sat_index", i < sgot_idx.size() ? sgot_idx[i] : '1, sexp_idx[i]);
    end
    got_dist.delete(); got_idx.delete(); got_done.delete(); got_cyc.delete();
    sgot_dist.delete(); sgot_idx.delete();
    exp_dist.delete(); exp_idx.delete(); exp_cyc.delete();
    sexp_dist.delete(); sexp_idx.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, d_ready, 0);
    chk({tag, "_valid"}, d_valid, 0);
    chk({tag, "_dist"}, d_dist, 0);
    chk({tag, "_index"}, d_index, 0);
    chk({tag, "_busy"}, d_busy, 0);
    chk({tag, "_done"}, d_done, 0);
    chk({tag, "_sdist"}, s_dist, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    @(negedge clk);

    // held-high stream, test (3,4)
    wr(0, 16'd3); wr(1, 16'd4); go();
    expect_pt(25, 25, 0, 0); push(0, 0, 0); push(0, 0, 1);
    expect_pt(0, 0, 1, 1);   push(3, 0, 0); push(4, 0, 1);
    expect_pt(25, 25, 2, 2); push(16'hFFFF, 0, 0); push(1, 1, 1);
    chk("ready_drop", d_ready, 0);
    in_valid = 0; in_last = 0;
    @(negedge clk);
    chk("done_pulse", d_done, 1);
    chk("done_valid", d_valid, 1);
    @(negedge clk);
    chk("busy_end", d_busy, 0);
    chk("done_end", d_done, 0);
    compare();

    // gaps, stray in_last, and start/test_wr during RUN
    go();
    expect_pt(25, 25, 0, 0); push(0, 1, 0); gap(); push(0, 0, 1);
    in_valid = 0;
    test_wr = 1; test_addr = 0; test_data = 16'd100; start = 1;
    @(negedge clk);
    test_wr = 0; start = 0;
    expect_pt(0, 0, 1, 1);   push(3, 0, 0); gap(); push(4, 0, 1); gap();
    expect_pt(25, 25, 2, 2); push(16'hFFFF, 0, 0); gap(); push(1, 1, 1);
    wait_idle();
    compare();

    // saturation and index wrap
    wr(0, 16'h8000); wr(1, 16'h8000); go();
    expect_pt(64'hFFFFFFFE, 64'hFFFE, 0, 0); push(16'h7FFF, 0, 0); push(16'h7FFF, 0, 1);
    expect_pt(4, 4, 1, 1);                   push(16'h8002, 0, 0); push(16'h8000, 0, 1);
    expect_pt(64'hFFFFFFFE, 64'hFFFE, 2, 2); push(16'h7FFF, 0, 0); push(16'h7FFF, 0, 1);
    expect_pt(0, 0, 3, 3);                   push(16'h8000, 0, 0); push(16'h8000, 0, 1);
    expect_pt(1, 1, 4, 0);                   push(16'h8000, 0, 0); push(16'h8001, 1, 1);
    wait_idle();
    compare();

    // reset in the middle of a point
    go();
    push(16'd5, 0, 0);
    in_valid = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    chk("rst_no_valid", got_dist.size(), 0);
    chk_zero("midrst");
    wr(0, 16'd3); wr(1, 16'd4); go();
    expect_pt(5, 5, 0, 0); push(4, 0, 0); push(6, 1, 1);
    wait_idle();
    compare();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/knn_distance_unit.md
# knn_distance_unit

Streaming squared-Euclidean distance stage of the KNN accelerator, directly upstream of the ordered list chain. Holds one test point in registers, consumes training-point coordinates one dimension per cycle, and emits each training point's squared distance plus its sequence index as a one-cycle pulse. The outputs `out_valid`/`out_dist`/`out_index` wire straight to every list unit's `valid`/`compIn`/`bagIn`.

## Interface
- `DATA_W`, 16, coordinate width, signed two's complement
- `DIMS`, 2, dimensions per point, ≥1
- `COMP_W`, 32, distance output width; matches list `COMP_W`
- `BAG_W`, 32, index output width; matches list `BAG_W`

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `test_wr`  in  1  write one test-point coordinate
- `test_addr`  in  max(1,clog2(DIMS))  dimension being written
- `test_data`  in  DATA_W  test coordinate value
- `start`  in  1  begin a dataset pass
- `in_valid`  in  1  training coordinate valid
- `in_ready`  out  1  unit accepts a coordinate this cycle
- `in_coord`  in  DATA_W  training coordinate, dimension order 0..DIMS-1
- `in_last`  in  1  marks the final training point; sampled only on its last-dimension coordinate
- `out_valid`  out  1  distance result pulse
- `out_dist`  out  COMP_W  squared distance, saturated
- `out_index`  out  BAG_W  zero-based training-point index
- `busy`  out  1  state is RUN or pipeline not empty
- `done`  out  1  one-cycle pulse with the final result

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: `in_ready`=0. `test_wr` writes `test_data` into test register `test_addr`; addresses ≥DIMS are ignored. `start` clears the dimension counter, index counter and accumulator, then moves to RUN. `test_wr` and `start` in the same cycle: both take effect; the new coordinate is used.
- RUN: `in_ready`=1. Each accepted coordinate (`in_valid & in_ready`) advances the dimension counter 0..DIMS-1, then wraps to 0.
- Pipeline stage 1 registers diff = in_coord − test[dim], DATA_W+1 bits signed.
- Pipeline stage 2 squares diff and adds the square to the accumulator. The accumulator is ACC_W = 2·DATA_W+2+clog2(DIMS) bits unsigned. On the first dimension of a point, the accumulator loads the square instead of adding it.
- Last-dimension completion: `out_dist` = min(acc, 2^COMP_W−2). All-ones is never emitted, because it is the list's empty marker and could never insert. `out_index` is the index counter; the counter then increments modulo 2^BAG_W, wrapping silently.
- If the last-dimension coordinate has `in_last`=1, go to DRAIN; `in_ready` drops from the next cycle.
- DRAIN: wait for the pipeline to empty, pulse `done` together with the final `out_valid`, return to IDLE.
- Ignored inputs: `start` outside IDLE; `test_wr` outside IDLE (the test point stays stable for the whole pass); `in_valid` in IDLE/DRAIN.
- No backpressure on the output. The list accepts one value per cycle.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_dist`=0, `out_index`=0, `busy`=0, `done`=0. State is IDLE, counters are 0, test registers are 0, pipeline valid bits are cleared.
- Reset mid-pass discards in-flight coordinates; no `out_valid` follows.
- `start` high in cycle n → `in_ready`=1 and `busy`=1 in cycle n+1.
- Last-dimension coordinate accepted in cycle n → `out_valid`=1 in cycle n+2 for exactly one cycle. `out_dist` and `out_index` are registered and held until the next result.
- Throughput: one point per DIMS cycles when `in_valid` is held high. Gaps in `in_valid` stall accumulation without corrupting it.
- Final point accepted in cycle n → `in_ready`=0 from n+1, `done`=`out_valid`=1 in n+2, `busy`=0 and IDLE in n+3.
- `in_last` on a non-final dimension has no effect.

## Test plan
- Basic distances: DIMS=2, test (3,4); stream (0,0), (3,4), (−1,1) with `in_last` on the third point → `out_dist` 25, 0, 25; `out_index` 0, 1, 2; `done` with the third result.
- Latency and throughput: `in_valid` held high → results exactly 2 cycles after each second coordinate, spaced 2 cycles apart. Random `in_valid` gaps → same values, delayed.
- Saturation: DATA_W=16, COMP_W=16, test (−32768,−32768), point (32767,32767) → `out_dist`=0xFFFE, never 0xFFFF.
- Index wrap: BAG_W=2, stream 5 points → indices 0, 1, 2, 3, 0.
- Illegal-time inputs: `test_wr` and `start` asserted during RUN → distances still use the original test point; no restart.
- Reset mid-point: assert `rst` after the first coordinate of a point → no `out_valid`, all outputs 0. A new `start` produces index 0 with a correct distance.
